// File: rtl/regfile_dump_ctrl.sv
// Purpose : walks RegisterFile read port 1 over addresses 0..2^ADDR_WIDTH-1 and streams each value out.
// Latency : 1 edge from an uncontended READ cycle to dump_valid; 2 cycles per beat minimum.
// Backpressure: a beat is held stable in HOLD until dump_ready; datapath reads (cpu_rd_req) stall READ.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start, abort         - begin a full dump (IDLE only) / cancel a dump in progress
//   cpu_rd_req, cpu_a1   - datapath read request and address (always has priority on A1)
//   rf_a1, rf_rd1        - RegisterFile A1 address out, RD1 data in
//   dump_valid/ready     - output stream handshake
//   dump_addr, dump_data - register index and captured value of the current beat
//   busy, done           - not-IDLE indicator, one-cycle pulse after the final beat
module regfile_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0] cpu_a1,
    output logic [ADDR_WIDTH-1:0] rf_a1,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_dump_valid;
    logic [ADDR_WIDTH-1:0] r_dump_addr;
    logic [DATA_WIDTH-1:0] r_dump_data;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  w_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_done_nxt;
    logic                  w_own_port;

    // The sequencer only takes the A1 port in an uncontended READ cycle.
    assign w_own_port = (r_state == S_READ) && !cpu_rd_req;
    assign rf_a1      = w_own_port ? r_ptr : cpu_a1;

    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_dump_valid;
        w_addr_nxt  = r_dump_addr;
        w_data_nxt  = r_dump_data;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_ptr_nxt   = '0;
                w_valid_nxt = 1'b0;
                if (start && !abort) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (!cpu_rd_req) begin
                    w_state_nxt = S_HOLD;
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = r_ptr;
                    w_data_nxt  = rf_rd1;
                end
            end
            S_HOLD: begin
                // abort wins over a handshake in the same cycle: the beat is dropped.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (dump_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_ptr == PTR_LAST) begin
                        // last address ends the dump; the pointer never wraps.
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_READ;
                        w_ptr_nxt   = r_ptr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_dump_valid <= w_valid_nxt;
            r_dump_addr  <= w_addr_nxt;
            r_dump_data  <= w_data_nxt;
            r_done       <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Purpose : self-checking bench for regfile_dump_ctrl with a behavioural 32-entry register file.
// Latency : expected beat order and done timing are derived from r[i]=3*i and the cycle rules.
// Backpressure: dump_ready and cpu_rd_req are driven by directed per-run vectors.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        cpu_rd_req;
    logic [4:0]  cpu_a1;
    logic [4:0]  rf_a1;
    logic [31:0] rf_rd1;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    assign rf_rd1 = rf[rf_a1];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } beat_t;

    beat_t exp_q [$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_dump_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cpu_rd_req (cpu_rd_req),
        .cpu_a1     (cpu_a1),
        .rf_a1      (rf_a1),
        .rf_rd1     (rf_rd1),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so at negedge the handshake
    // condition for the coming edge is stable.
    always @(negedge clk) begin
        if (!reset && dump_valid && dump_ready && !abort) begin
            beat_t b;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat actual_addr=%0d required=none", dump_addr);
            end else begin
                b = exp_q.pop_front();
                if (dump_addr !== b.a || dump_data !== b.d) begin
                    bad++;
                    $display("FAIL beat actual=%0d/%0d required=%0d/%0d",
                             dump_addr, dump_data, b.a, b.d);
                end
            end
        end
    end

    // One dump run. Negative addresses disable the abort / reset / backpressure events.
    task automatic run_dump(input int bp_addr, input int bp_n, input int ct_n,
                            input int ab_addr, input int rst_addr,
                            input bit start_mid, input int exp_lat);
        int n_beats, start_cyc, bp_left, ct_left;
        bit finished;
        n_beats = 32;
        if (ab_addr >= 0)  n_beats = ab_addr;
        if (rst_addr >= 0) n_beats = rst_addr;
        for (int i = 0; i < n_beats; i++) begin
            beat_t b;
            b.a = 5'(i);
            b.d = 32'(3 * i);
            exp_q.push_back(b);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", int'(busy), 1);
        check("valid_after_start", int'(dump_valid), 0);
        bp_left  = bp_n;
        ct_left  = ct_n;
        finished = 1'b0;
        for (int k = 0; k < 400 && !finished; k++) begin
            dump_ready = 1'b1;
            cpu_rd_req = 1'b0;
            abort      = 1'b0;
            start      = 1'b0;
            if (done) begin
                check("done_latency", cyc - start_cyc, exp_lat);
                check("busy_with_done", int'(busy), 0);
                check("valid_with_done", int'(dump_valid), 0);
                @(posedge clk); #1;
                check("done_one_cycle", int'(done), 0);
                finished = 1'b1;
            end else if (ab_addr >= 0 && dump_valid && int'(dump_addr) == ab_addr) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_valid", int'(dump_valid), 0);
                check("abort_busy", int'(busy), 0);
                for (int j = 0; j < 3; j++) begin
                    check("abort_no_done", int'(done), 0);
                    @(posedge clk); #1;
                end
                finished = 1'b1;
            end else if (rst_addr >= 0 && dump_valid && int'(dump_addr) == rst_addr) begin
                #2 reset = 1'b1;
                #1;
                check("rst_valid", int'(dump_valid), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_data", int'(dump_data), 0);
                check("rst_done", int'(done), 0);
                @(posedge clk); #1;
                reset = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(posedge clk); #1;
                    check("post_rst_idle_busy", int'(busy), 0);
                    check("post_rst_idle_done", int'(done), 0);
                end
                finished = 1'b1;
            end else begin
                if (bp_left > 0 && dump_valid && int'(dump_addr) == bp_addr) begin
                    dump_ready = 1'b0;
                    bp_left--;
                    #1;
                    check("bp_addr_stable", int'(dump_addr), bp_addr);
                    check("bp_data_stable", int'(dump_data), 3 * bp_addr);
                end
                // READ at ptr 10: the previous beat (addr 9) has just been accepted.
                if (ct_left > 0 && busy && !dump_valid && dump_addr == 5'd9) begin
                    cpu_rd_req = 1'b1;
                    cpu_a1     = 5'd7;
                    ct_left--;
                    #1;
                    check("cpu_rf_a1", int'(rf_a1), 7);
                    check("cpu_rd1", int'(rf_rd1), 21);
                end
                if (start_mid && dump_valid && dump_addr == 5'd15) start = 1'b1;
                @(posedge clk); #1;
            end
        end
        if (!finished) check("run_timeout", 0, 1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        dump_ready = 1'b1;
        cpu_rd_req = 1'b0;
        abort      = 1'b0;
        start      = 1'b0;
        cpu_a1     = 5'd5;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cpu_rd_req = 1'b0;
        cpu_a1     = 5'd5;
        dump_ready = 1'b1;
        #2;
        check("reset_valid", int'(dump_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_addr", int'(dump_addr), 0);
        check("reset_data", int'(dump_data), 0);
        check("reset_rf_a1", int'(rf_a1), 5);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_rf_a1", int'(rf_a1), 5);

        run_dump(-1, 0, 0, -1, -1, 1'b0, 64);  // plain full dump
        run_dump( 5, 3, 0, -1, -1, 1'b0, 67);  // backpressure on addr 5
        run_dump(-1, 0, 4, -1, -1, 1'b0, 68);  // CPU contention at ptr 10
        run_dump(-1, 0, 0, -1, -1, 1'b1, 64);  // start while busy is ignored
        run_dump(-1, 0, 0, 12, -1, 1'b0, 0);   // abort in HOLD at addr 12
        run_dump(-1, 0, 0, -1, -1, 1'b0, 64);  // restart from addr 0

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("start_abort_busy", int'(busy), 0);
            check("start_abort_valid", int'(dump_valid), 0);
            @(posedge clk); #1;
        end

        run_dump(-1, 0, 0, -1, 20, 1'b0, 0);   // reset at addr 20

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Sequencer that owns read port 1 (A1/RD1) of the 32-entry MIPS `RegisterFile` and walks every register out over a valid/ready stream, so a bench or debug host can dump the full register file. The sequencer shares the port with the CPU datapath, and the datapath always wins. It sits between the datapath's A1 source and the register file's A1 input, and taps RD1.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: register width; matches RD1.
- `ADDR_WIDTH`, default 5: register address width; the dump covers 0 .. 2^ADDR_WIDTH-1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high; forces the reset state immediately.
- `start`, input, 1: request a full dump; sampled only in IDLE.
- `abort`, input, 1: cancel a dump in progress.
- `cpu_rd_req`, input, 1: datapath needs the A1 port this cycle (priority).
- `cpu_a1`, input, ADDR_WIDTH: datapath read address.
- `rf_a1`, output, ADDR_WIDTH: address driven into RegisterFile A1 (combinational mux).
- `rf_rd1`, input, DATA_WIDTH: RegisterFile RD1 (combinational read).
- `dump_valid`, output, 1: `dump_addr`/`dump_data` hold a beat.
- `dump_ready`, input, 1: consumer accepts the beat.
- `dump_addr`, output, ADDR_WIDTH: register index of the current beat.
- `dump_data`, output, DATA_WIDTH: captured register value.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, READ, HOLD; internal pointer `ptr` (ADDR_WIDTH bits).
- IDLE: `ptr`=0, `dump_valid`=0. `start`=1 and `abort`=0 -> READ.
- READ: if `cpu_rd_req`=0, capture `rf_rd1` into `dump_data` and `ptr` into `dump_addr`, set `dump_valid`=1, go to HOLD. If `cpu_rd_req`=1, stay in READ with no capture (stall).
- HOLD: hold `dump_valid`, `dump_addr` and `dump_data` stable.
  - On `dump_ready`=1 with `ptr`=all-ones: go to IDLE, `dump_valid`=0, pulse `done`.
  - On `dump_ready`=1 otherwise: `ptr`+1, go to READ, `dump_valid`=0.
- Mux: `rf_a1` = `ptr` when state=READ and `cpu_rd_req`=0; otherwise `rf_a1` = `cpu_a1`. The CPU read path is never blocked.
- `abort`=1 in READ or HOLD -> IDLE next edge: `dump_valid`=0, `ptr`=0, no `done`. `abort` beats `dump_ready` in the same cycle.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE -> stay in IDLE.
- `ptr` never wraps: the last address terminates the dump.
- Values are reported exactly as returned by RD1, including register 0.

## Timing
- Reset values: state IDLE; `ptr`, `dump_valid`, `dump_addr`, `dump_data`, `busy` and `done` all 0; `rf_a1` = `cpu_a1`.
- `start` sampled at edge N -> `busy`=1 after edge N, READ during cycle N+1.
- Read-to-valid: 1 edge. The RD1 value in the uncontended READ cycle appears on `dump_data` with `dump_valid`=1 after that edge.
- Each beat takes at least 2 cycles (READ + HOLD). Each stalled READ cycle adds 1 cycle; each HOLD cycle with `dump_ready`=0 adds 1 cycle.
- Uncontended dump with `dump_ready` tied high: 64 cycles from entering READ to `done`. `done` is high for the cycle after the final handshake edge, and `busy`=0 in that same cycle.
- A transfer occurs only on an edge where `dump_valid`=1 and `dump_ready`=1.
- `reset` asserted mid-dump: outputs clear immediately (asynchronous), and there is no `done`.

## Test plan
- Full dump: preload r[i]=3*i (r0=0), `dump_ready`=1, pulse `start` -> 32 beats with `dump_addr` 0..31 and `dump_data` 0,3,..,93, in order; `done` pulses once, 64 cycles after READ entry; `busy` falls with it.
- Backpressure: `dump_ready` low for 3 cycles on the beat at addr 5 -> `dump_addr`=5 and `dump_data`=15 stay stable while waiting; no beat is skipped or duplicated; total latency is +3 cycles.
- Contention: `cpu_rd_req`=1 with `cpu_a1`=7 for 4 cycles while in READ at `ptr`=10 -> `rf_a1`=7 and the CPU sees r7=21 throughout; the dump resumes and emits addr 10 data 30; total latency is +4 cycles.
- Abort: assert `abort` in HOLD at addr 12, with `dump_ready` high in the same cycle -> no transfer counted; IDLE next cycle; `dump_valid`=0; no `done`. A new `start` then restarts at addr 0.
- Reset mid-dump at addr 20 -> `dump_valid`, `busy` and `dump_data` go to 0 without waiting for a clock edge; after release, the block idles until `start`.
- `start` pulsed while busy, and `start`+`abort` together in IDLE -> both ignored; the current dump completes unchanged in the first case, and the block stays idle in the second.
